// File: rtl/mlen_id_decoder.sv
// Receive-side m_len -> link ID decoder: sequential search of the fixed link-ID table,
// one 13-bit compare per clock, ascending from ID 4 to ID 34.
module mlen_id_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] m_len_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [5:0]  link_id
);

    localparam logic [5:0] FirstId = 6'd4;
    localparam logic [5:0] LastId  = 6'd34;

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e      state_q, state_d;
    logic [12:0] m_len_q, m_len_d;
    logic [5:0]  idx_q, idx_d;
    logic        found_q, found_d;
    logic [5:0]  link_id_q, link_id_d;
    logic [12:0] tbl_val;

    always_comb begin
        tbl_val = 13'h0000;
        unique case (idx_q)
            6'd4:    tbl_val = 13'h03b8;
            6'd5:    tbl_val = 13'h0120;
            6'd6:    tbl_val = 13'h02a0;
            6'd7:    tbl_val = 13'h0420;
            6'd8:    tbl_val = 13'h00c0;
            6'd9:    tbl_val = 13'h01c0;
            6'd10:   tbl_val = 13'h02c0;
            6'd11:   tbl_val = 13'h01b0;
            6'd12:   tbl_val = 13'h03cc;
            6'd13:   tbl_val = 13'h0510;
            6'd14:   tbl_val = 13'h0380;
            6'd15:   tbl_val = 13'h07e0;
            6'd16:   tbl_val = 13'h0a80;
            6'd17:   tbl_val = 13'h0750;
            6'd18:   tbl_val = 13'h0fc0;
            6'd19:   tbl_val = 13'h15f0;
            6'd20:   tbl_val = 13'h0060;
            6'd21:   tbl_val = 13'h02e0;
            6'd22:   tbl_val = 13'h0c30;
            6'd23:   tbl_val = 13'h11c0;
            6'd24:   tbl_val = 13'h0ecc;
            6'd25:   tbl_val = 13'h12a8;
            6'd26:   tbl_val = 13'h1550;
            6'd27:   tbl_val = 13'h1790;
            6'd28:   tbl_val = 13'h14a0;
            6'd29:   tbl_val = 13'h15b0;
            6'd30:   tbl_val = 13'h14c8;
            6'd31:   tbl_val = 13'h14d0;
            6'd32:   tbl_val = 13'h0138;
            6'd33:   tbl_val = 13'h10b8;
            6'd34:   tbl_val = 13'h1040;
            default: tbl_val = 13'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_len_q   <= 13'h0000;
            idx_q     <= 6'd0;
            found_q   <= 1'b0;
            link_id_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            m_len_q   <= m_len_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
            link_id_q <= link_id_d;
        end
    end

    // Idle/Done never compare, so an idx of 0 can never alias a real table entry.
    always_comb begin
        state_d   = state_q;
        m_len_d   = m_len_q;
        idx_d     = idx_q;
        found_d   = found_q;
        link_id_d = link_id_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_len_d = m_len_in;
                    idx_d   = FirstId;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (tbl_val == m_len_q) begin
                    found_d   = 1'b1;
                    link_id_d = idx_q;
                    state_d   = StDone;
                end else if (idx_q == LastId) begin
                    found_d   = 1'b0;
                    link_id_d = 6'd0;
                    state_d   = StDone;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        found   = found_q;
        link_id = link_id_q;
    end

endmodule

// File: tb/tb_mlen_id_decoder.sv
// Self-checking bench for mlen_id_decoder: table-driven requests with a result scoreboard,
// plus hand-written ignored-start, back-to-back and mid-search reset sequences.
module tb_mlen_id_decoder;

    logic        clk;
    logic        rst;
    logic [12:0] m_len_in;
    logic        start;
    logic        busy;
    logic        done;
    logic        found;
    logic [5:0]  link_id;

    int checks;
    int errors;

    typedef struct {
        logic [12:0] m;
        logic        f;
        logic [5:0]  id;
        int          lat;
    } vec_t;

    typedef struct {
        logic        f;
        logic [5:0]  id;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic       prev_f;
    logic [5:0] prev_id;

    mlen_id_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .m_len_in (m_len_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .link_id  (link_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives start in the current cycle (cycle 0) and advances into cycle 1.
    task automatic issue(input logic [12:0] m, input bit push, input logic f,
                         input logic [5:0] id, input int lat);
        exp_t e;
        start    = 1'b1;
        m_len_in = m;
        if (push) begin
            e.f = f; e.id = id; e.lat = lat;
            sb.push_back(e);
        end
        tick();
        start    = 1'b0;
        m_len_in = 13'h1fff;
    endtask

    // Runs from cycle 1 until done, checking busy/hold each cycle, then checks the cycle after.
    task automatic run_search(input int inj_cyc, input logic [12:0] inj_m);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.lat);
                    chk("found", int'(found), int'(e.f));
                    chk("link_id", int'(link_id), int'(e.id));
                    chk("busy_in_done", int'(busy), 1);
                    prev_f  = e.f;
                    prev_id = e.id;
                end
            end else begin
                if (busy !== 1'b1) chk("busy_in_search", int'(busy), 1);
                if (found !== prev_f || link_id !== prev_id) begin
                    chk("hold_found", int'(found), int'(prev_f));
                    chk("hold_link_id", int'(link_id), int'(prev_id));
                end
                if (cyc == inj_cyc) begin
                    start    = 1'b1;
                    m_len_in = inj_m;
                end
                tick();
                start = 1'b0;
                cyc++;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        tick();
        chk("done_after", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("found_after", int'(found), int'(prev_f));
        chk("link_id_after", int'(link_id), int'(prev_id));
    endtask

    vec_t vecs[10];
    int   any_done;

    initial begin
        checks   = 0;
        errors   = 0;
        prev_f   = 1'b0;
        prev_id  = 6'd0;
        start    = 1'b0;
        m_len_in = 13'h0000;
        rst      = 1'b1;

        vecs[0] = '{m: 13'h03b8, f: 1'b1, id: 6'h04, lat: 2};
        vecs[1] = '{m: 13'h1040, f: 1'b1, id: 6'h22, lat: 32};
        vecs[2] = '{m: 13'h15f0, f: 1'b1, id: 6'h13, lat: 17};
        vecs[3] = '{m: 13'h0000, f: 1'b0, id: 6'h00, lat: 32};
        vecs[4] = '{m: 13'h0001, f: 1'b0, id: 6'h00, lat: 32};
        vecs[5] = '{m: 13'h0fc0, f: 1'b1, id: 6'h12, lat: 16};
        vecs[6] = '{m: 13'h0060, f: 1'b1, id: 6'h14, lat: 18};
        vecs[7] = '{m: 13'h0ecd, f: 1'b0, id: 6'h00, lat: 32};
        vecs[8] = '{m: 13'h0120, f: 1'b1, id: 6'h05, lat: 3};
        vecs[9] = '{m: 13'h10b8, f: 1'b1, id: 6'h21, lat: 31};

        tick();
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_link_id", int'(link_id), 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            issue(vecs[i].m, 1'b1, vecs[i].f, vecs[i].id, vecs[i].lat);
            run_search(0, 13'h0000);
            // Idle gap: outputs must keep the last result.
            repeat (3) tick();
            chk("idle_hold_found", int'(found), int'(prev_f));
            chk("idle_hold_link_id", int'(link_id), int'(prev_id));
        end

        // Start ignored in cycle 5, then a back-to-back start right after done.
        issue(13'h0c30, 1'b1, 1'b1, 6'h16, 20);
        run_search(5, 13'h03b8);
        chk("sb_empty_after_ignore", sb.size(), 0);
        issue(13'h0120, 1'b1, 1'b1, 6'h05, 3);
        run_search(0, 13'h0000);

        // Mid-search asynchronous reset in cycle 10.
        issue(13'h1790, 1'b0, 1'b0, 6'h00, 0);
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_link_id", int'(link_id), 0);
        #2;
        rst     = 1'b0;
        prev_f  = 1'b0;
        prev_id = 6'd0;
        any_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) any_done++;
        end
        chk("no_done_after_rst", any_done, 0);
        issue(13'h1790, 1'b1, 1'b1, 6'h1b, 25);
        run_search(0, 13'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
